pwm_duty_decoder: RTL and testbench

//  Receive-side counterpart of the RGB PWM generator: measures an incoming PWM

---
 rtl/pwm_duty_decoder.sv | 132 +++++++++++++
 tb/tb_pwm_duty_decoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: recovers high time, period and 3-bit duty level of a PWM input, with timeout.
// Define PWM_DEGLITCH_EN to add a DEGLITCH-sample stability filter after the synchroniser.
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 60000
`ifdef PWM_DEGLITCH_EN
  ,
  parameter int DEGLITCH = 3
`endif
) (
  input  logic             tp_clk,
  input  logic             tp_rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [2:0]       level,
  output logic             meas_valid,
  output logic             timeout
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic             sync1_q, sync2_q, s, s_prev_q, rise, fall, per_max;
  state_t           state_q;
  logic [CNT_W-1:0] hi_cnt_q, per_cnt_q, per_d, high_time_q, period_q;
  logic             meas_valid_q, timeout_q;
  logic [CNT_W+2:0] ht8, acc;
  logic [2:0]       lvl;
  always_ff @(posedge tp_clk or negedge tp_rst)
    if (!tp_rst) {sync1_q, sync2_q} <= 2'b00;
    else {sync1_q, sync2_q} <= {pwm_in, sync1_q};
`ifdef PWM_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH + 1);
  logic [DW-1:0] dg_q;
  logic          s_q;
  // s follows the synchroniser only after DEGLITCH consecutive differing samples
  always_ff @(posedge tp_clk or negedge tp_rst)
    if (!tp_rst) begin
      dg_q <= '0;
      s_q  <= 1'b0;
    end else if (sync2_q == s_q) dg_q <= '0;
    else if (dg_q == DW'(DEGLITCH - 1)) begin
      dg_q <= '0;
      s_q  <= sync2_q;
    end else dg_q <= dg_q + 1'b1;
  assign s = s_q;
`else
  assign s = sync2_q;
`endif
  assign rise    = s & ~s_prev_q;
  assign fall    = ~s & s_prev_q;
  assign per_max = per_cnt_q == TO;
  assign per_d   = per_max ? per_cnt_q : per_cnt_q + 1'b1;
  always_ff @(posedge tp_clk or negedge tp_rst) begin
    if (!tp_rst) begin
      s_prev_q     <= 1'b0;
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      per_cnt_q    <= '0;
      high_time_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      s_prev_q     <= s;
      meas_valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (rise) begin
          state_q   <= HIGH;
          hi_cnt_q  <= ONE;
          per_cnt_q <= ONE;
        end else if (s) per_cnt_q <= '0;
        else if (per_max) begin
          per_cnt_q    <= '0;
          high_time_q  <= '0;
          period_q     <= TO;
          meas_valid_q <= 1'b1;
          timeout_q    <= 1'b1;
        end else per_cnt_q <= per_d;
      end else if (state_q == HIGH) begin
        if (fall) begin
          state_q   <= LOW;
          per_cnt_q <= per_d;
        end else if (per_max) begin
          state_q      <= IDLE;
          hi_cnt_q     <= '0;
          per_cnt_q    <= '0;
          high_time_q  <= TO;
          period_q     <= TO;
          meas_valid_q <= 1'b1;
          timeout_q    <= 1'b1;
        end else begin
          hi_cnt_q  <= hi_cnt_q + 1'b1;
          per_cnt_q <= per_d;
        end
      end else begin
        if (rise) begin
          state_q      <= HIGH;
          high_time_q  <= hi_cnt_q;
          period_q     <= per_cnt_q;
          hi_cnt_q     <= ONE;
          per_cnt_q    <= ONE;
          meas_valid_q <= 1'b1;
          timeout_q    <= 1'b0;
        end else if (per_max) begin
          state_q      <= IDLE;
          hi_cnt_q     <= '0;
          per_cnt_q    <= '0;
          high_time_q  <= '0;
          period_q     <= TO;
          meas_valid_q <= 1'b1;
          timeout_q    <= 1'b1;
        end else per_cnt_q <= per_d;
      end
    end
  end
  // level counts the multiples k*period (k=1..7) not exceeding 8*high_time
  always_comb begin
    ht8 = {high_time_q, 3'b000};
    acc = '0;
    lvl = '0;
    for (int k = 1; k < 8; k++) begin
      acc = acc + {3'b000, period_q};
      lvl = lvl + {2'b00, ht8 >= acc};
    end
  end
  assign high_time  = high_time_q;
  assign period     = period_q;
  assign level      = (period_q == '0) ? 3'd0 : lvl;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: scoreboard bench for pwm_duty_decoder, TIMEOUT shortened to 300 cycles.
module tb_pwm_duty_decoder;
  localparam int CNT_W = 16;
  localparam int TO    = 300;
`ifdef PWM_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  typedef struct packed {
    logic [CNT_W-1:0] ht;
    logic [CNT_W-1:0] per;
    logic [2:0]       lvl;
    logic             to;
  } exp_t;
  logic             clk = 1'b0, rst_n = 1'b0, pwm = 1'b0;
  logic [CNT_W-1:0] ht, per;
  logic [2:0]       lvl;
  logic             mv, tmo;
  exp_t             exp_q[$];
  exp_t             got, want;
  int               vectors = 0, miscompares = 0, pulses = 0;
  bit               armed = 1'b0;
  int               prev_hi = 0, prev_per = 0;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .tp_clk(clk), .tp_rst(rst_n), .pwm_in(pwm), .high_time(ht), .period(per),
    .level(lvl), .meas_valid(mv), .timeout(tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] lvl_model(int h, int p);
    int n = 0;
    if (p == 0) return 3'd0;
    for (int k = 1; k <= 7; k++) if (h * 8 >= k * p) n++;
    return 3'(n);
  endfunction

  task automatic expect_meas(int h, int p, logic t);
    exp_q.push_back('{ht: CNT_W'(h), per: CNT_W'(p), lvl: lvl_model(h, p), to: t});
  endtask

  always @(negedge clk) if (rst_n && mv) begin
    pulses++;
    vectors++;
    got = '{ht: ht, per: per, lvl: lvl, to: tmo};
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL meas_unexpected: got ht=%0d per=%0d lvl=%0d to=%0b, required no meas_valid",
               ht, per, lvl, tmo);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL meas: got ht=%0d per=%0d lvl=%0d to=%0b, required ht=%0d per=%0d lvl=%0d to=%0b",
                 got.ht, got.per, got.lvl, got.to, want.ht, want.per, want.lvl, want.to);
      end
    end
  end

  task automatic drive(logic v, int n);
    pwm = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_cycle(int h, int p);
    if (armed) expect_meas(prev_hi, prev_per, 1'b0);
    prev_hi  = h;
    prev_per = p;
    armed    = 1'b1;
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic pwm_last();
    if (armed) expect_meas(prev_hi, prev_per, 1'b0);
    armed = 1'b0;
    drive(1'b1, 5);
    drive(1'b0, 5);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pwm   = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    repeat (LAT + 10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pwm   = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ht, per, lvl, mv, tmo} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", {ht, per, lvl, mv, tmo});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    apply_reset();
    pwm_cycle(10, 40);
    armed = 1'b0;
    expect_meas(10, 40, 1'b0);
    pwm = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    vectors++;
    if (mv !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: meas_valid=%b one cycle early, required 0", mv);
    end
    @(negedge clk);
    vectors++;
    if (mv !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_on_time: meas_valid=%b, required 1", mv);
    end
    prev_hi  = 10;
    prev_per = 40;
    armed    = 1'b1;
    drive(1'b1, 10 - LAT);
    drive(1'b0, 30);
    pwm_last();
    drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL latency_pending: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_basic();
    int p0;
    apply_reset();
    p0 = pulses;
    repeat (4) pwm_cycle(25, 100);
    armed = 1'b0;
    drain();
    vectors++;
    if (pulses - p0 !== 3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_count: pulses=%0d pending=%0d, required 3 and 0", pulses - p0, exp_q.size());
    end
  endtask

  task automatic test_levels();
    int h, p;
    apply_reset();
    pwm_cycle(79, 80);
    pwm_cycle(9, 80);
    pwm_cycle(10, 80);
    for (int i = 0; i < 6; i++) begin
      p = int'($urandom_range(250, 8));
      h = int'($urandom_range(p - 4, 4));
      pwm_cycle(h, p);
    end
    pwm_last();
    drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL levels_pending: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int p0;
    apply_reset();
    p0 = pulses;
    expect_meas(TO, TO, 1'b1);
    drive(1'b1, TO + 50);
    vectors++;
    if (pulses - p0 !== 1 || tmo !== 1'b1 || lvl !== 3'd7) begin
      miscompares++;
      $display("FAIL stuck_high: pulses=%0d to=%b lvl=%0d, required 1 1 7", pulses - p0, tmo, lvl);
    end
    expect_meas(0, TO, 1'b1);
    drive(1'b0, TO + 50);
    vectors++;
    if (pulses - p0 !== 2 || tmo !== 1'b1 || ht !== '0 || lvl !== 3'd0) begin
      miscompares++;
      $display("FAIL stuck_low: pulses=%0d to=%b ht=%0d lvl=%0d, required 2 1 0 0",
               pulses - p0, tmo, ht, lvl);
    end
    pwm_cycle(30, 60);
    pwm_cycle(30, 60);
    pwm_last();
    drain();
    vectors++;
    if (tmo !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_clear: to=%b pending=%0d, required 0 and 0", tmo, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    apply_reset();
    pwm_cycle(20, 50);
    pwm_cycle(20, 50);
    armed = 1'b0;
    expect_meas(20, 50, 1'b0);
    pwm = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (ht !== 16'd20) begin
      miscompares++;
      $display("FAIL mid_pre: ht=%0d, required 20", ht);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ht, per, lvl, mv, tmo} !== '0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got %h, required 0", {ht, per, lvl, mv, tmo});
    end
    @(negedge clk);
    pwm = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    pwm_cycle(20, 50);
    vectors++;
    if (pulses - p0 !== 0) begin
      miscompares++;
      $display("FAIL mid_first_rise: pulses=%0d, required 0", pulses - p0);
    end
    pwm_cycle(15, 50);
    pwm_last();
    drain();
    vectors++;
    if (pulses - p0 !== 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_after: pulses=%0d pending=%0d, required 2 and 0", pulses - p0, exp_q.size());
    end
  endtask

  task automatic test_edge_timeout();
    apply_reset();
    pwm_cycle(100, TO);
    pwm_cycle(100, TO);
    pwm_last();
    drain();
    vectors++;
    if (tmo !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL edge_timeout: to=%b pending=%0d, required 0 and 0", tmo, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    pwm_cycle(60, 100);
    armed = 1'b0;
    expect_meas(60, 100, 1'b0);
    drive(1'b1, 20);
    drive(1'b0, 2);
`ifndef PWM_DEGLITCH_EN
    expect_meas(20, 22, 1'b0);
`endif
    drive(1'b1, 38);
    drive(1'b0, 40);
`ifdef PWM_DEGLITCH_EN
    expect_meas(60, 100, 1'b0);
`else
    expect_meas(38, 78, 1'b0);
`endif
    drive(1'b1, 5);
    drive(1'b0, 5);
    drain();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL glitch_pending: %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_basic();
    test_levels();
    test_timeout();
    test_reset_mid();
    test_edge_timeout();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
